icache_refill_unit: RTL and testbench

Miss-handling refill engine between the 2-way instruction cache and main memory. On a cache miss it fetches one full cache line from main memory, one word per handshake, critical word first with wrap-around. It streams each word to the cache fill port and flags the critical word so IF can resume early. It also keeps a saturating refill counter.

---
 rtl/icache_refill_unit_pkg.sv | 18 +
 rtl/icache_refill_unit_if.sv | 38 +++
 rtl/icache_refill_unit_counter.sv | 20 ++
 rtl/icache_refill_unit.sv | 103 ++++++++++
 tb/tb_icache_refill_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_unit_pkg.sv
// Shared constants for the I-cache refill engine: FSM encoding, line geometry and address helpers.
// Pure declarations, no logic or latency of its own.
package icache_refill_unit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int LINE_WORDS_DEF = 4;
    localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
    localparam int LINE_BYTES     = 4 * LINE_WORDS_DEF;

    // Line base of a byte address for a line of line_bytes bytes (power of 2).
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_bytes);
        return addr & ~(32'(line_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// Cache/memory-side bundle of the refill engine; master = cache+memory side, slave = refill unit.
// Memory handshake is Mem_Req held until Mem_Valid; fill/crit/done outputs are single-cycle pulses.
interface icache_refill_unit_if #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 20
);
    localparam int IW = $clog2(LINE_WORDS);

    logic             Miss_Req;
    logic [31:0]      Miss_Addr;
    logic             Abort;
    logic             Mem_Req;
    logic [31:0]      Mem_Addr;
    logic             Mem_Valid;
    logic [31:0]      Mem_Data;
    logic             Fill_Valid;
    logic [IW-1:0]    Fill_Word_Idx;
    logic [31:0]      Fill_Data;
    logic [31:0]      Fill_Tag_Addr;
    logic             Fill_Done;
    logic             Crit_Valid;
    logic [31:0]      Crit_Data;
    logic             Busy;
    logic [CNT_W-1:0] Refill_Count;

    modport master (
        output Miss_Req, Miss_Addr, Abort, Mem_Valid, Mem_Data,
        input  Mem_Req, Mem_Addr, Fill_Valid, Fill_Word_Idx, Fill_Data, Fill_Tag_Addr,
               Fill_Done, Crit_Valid, Crit_Data, Busy, Refill_Count
    );

    modport slave (
        input  Miss_Req, Miss_Addr, Abort, Mem_Valid, Mem_Data,
        output Mem_Req, Mem_Addr, Fill_Valid, Fill_Word_Idx, Fill_Data, Fill_Tag_Addr,
               Fill_Done, Crit_Valid, Crit_Data, Busy, Refill_Count
    );

endinterface

// File: rtl/icache_refill_unit_counter.sv
// refill_counter: W-bit saturating event counter with enable and synchronous active-low clear.
// Count visible one cycle after the enabled edge; holds at all-ones, no backpressure.
module refill_counter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/icache_refill_unit.sv
// Critical-word-first line refill: one word per Mem_Valid, wrapping in the line, pulses fill/crit/done.
// Fill pulse one cycle after each ack, Fill_Done one cycle after the last; Mem_Req holds until each ack.
module icache_refill_unit
    import icache_refill_unit_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int CNT_W      = 20
) (
    input  logic                   CLK,
    input  logic                   RESET,
    icache_refill_unit_if.slave    bus
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

    logic [1:0]    state_q;
    logic [31:0]   base_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] cnt_q;
    logic          abort_q;
    logic          fill_valid_q;
    logic [IW-1:0] fill_idx_q;
    logic [31:0]   fill_data_q;
    logic          fill_done_q;
    logic          crit_valid_q;
    logic [31:0]   crit_data_q;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.Miss_Addr[1:0];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            fill_done_q  <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            fill_valid_q <= 1'b0;
            fill_done_q  <= 1'b0;
            crit_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.Miss_Req) begin
                        base_q  <= line_base(bus.Miss_Addr, 4 * LINE_WORDS);
                        idx_q   <= bus.Miss_Addr[IW+1:2];
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus.Abort) abort_q <= 1'b1;
                    if (bus.Mem_Valid) begin
                        fill_valid_q <= 1'b1;
                        fill_idx_q   <= idx_q;
                        fill_data_q  <= bus.Mem_Data;
                        idx_q        <= idx_q + IW'(1);
                        cnt_q        <= cnt_q + IW'(1);
                        // IF only resumes early if no flush has hit this refill yet
                        if ((cnt_q == '0) && !abort_q && !bus.Abort) begin
                            crit_valid_q <= 1'b1;
                            crit_data_q  <= bus.Mem_Data;
                        end
                        if (cnt_q == LAST) begin
                            fill_done_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Busy          = (state_q != ST_IDLE);
    assign bus.Mem_Req       = (state_q == ST_FETCH);
    assign bus.Mem_Addr      = (state_q == ST_FETCH) ?
                               (base_q + {{(30-IW){1'b0}}, idx_q, 2'b00}) : 32'd0;
    assign bus.Fill_Valid    = fill_valid_q;
    assign bus.Fill_Word_Idx = fill_idx_q;
    assign bus.Fill_Data     = fill_data_q;
    assign bus.Fill_Tag_Addr = base_q;
    assign bus.Fill_Done     = fill_done_q;
    assign bus.Crit_Valid    = crit_valid_q;
    assign bus.Crit_Data     = crit_data_q;

    refill_counter #(.W(CNT_W)) u_refill_counter (
        .clk     (CLK),
        .clear_n (RESET),
        .en      (state_q == ST_DONE),
        .count   (bus.Refill_Count)
    );

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized bench: drives two refill units (CNT_W=20 and CNT_W=2) from one stimulus stream
// and compares every output against a line-level model of the refill sequence.
module tb_icache_refill_unit;

    localparam int LW = 4;

    logic        CLK;
    logic        rst_n;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        abort;
    logic        mem_valid;
    logic [31:0] mem_data;

    int n_chk;
    int n_err;
    int n_done;

    icache_refill_unit_if #(.LINE_WORDS(LW), .CNT_W(20)) ifa ();
    icache_refill_unit_if #(.LINE_WORDS(LW), .CNT_W(2))  ifb ();

    assign ifa.Miss_Req  = miss_req;
    assign ifa.Miss_Addr = miss_addr;
    assign ifa.Abort     = abort;
    assign ifa.Mem_Valid = mem_valid;
    assign ifa.Mem_Data  = mem_data;
    assign ifb.Miss_Req  = miss_req;
    assign ifb.Miss_Addr = miss_addr;
    assign ifb.Abort     = abort;
    assign ifb.Mem_Valid = mem_valid;
    assign ifb.Mem_Data  = mem_data;

    icache_refill_unit #(.LINE_WORDS(LW), .CNT_W(20)) dut_a (.CLK(CLK), .RESET(rst_n), .bus(ifa));
    icache_refill_unit #(.LINE_WORDS(LW), .CNT_W(2))  dut_b (.CLK(CLK), .RESET(rst_n), .bus(ifb));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_counts();
        chk("refill_count", 32'(ifa.Refill_Count), 32'(n_done));
        chk("refill_count_sat", 32'(ifb.Refill_Count), (n_done > 3) ? 32'd3 : 32'(n_done));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},     32'(ifa.Busy), 0);
        chk({tag, "_mem_req"},  32'(ifa.Mem_Req), 0);
        chk({tag, "_mem_addr"}, ifa.Mem_Addr, 0);
        chk({tag, "_fill_vld"}, 32'(ifa.Fill_Valid), 0);
        chk({tag, "_fill_idx"}, 32'(ifa.Fill_Word_Idx), 0);
        chk({tag, "_fill_dat"}, ifa.Fill_Data, 0);
        chk({tag, "_tag_addr"}, ifa.Fill_Tag_Addr, 0);
        chk({tag, "_done"},     32'(ifa.Fill_Done), 0);
        chk({tag, "_crit_vld"}, 32'(ifa.Crit_Valid), 0);
        chk({tag, "_crit_dat"}, ifa.Crit_Data, 0);
        chk({tag, "_cnt_a"},    32'(ifa.Refill_Count), 0);
        chk({tag, "_cnt_b"},    32'(ifb.Refill_Count), 0);
    endtask

    // One refill as seen from outside: memory acks on every (gap+1)-th FETCH cycle,
    // Abort pulsed in FETCH cycle abort_at, reset asserted once rst_acks words are in.
    task automatic refill(input logic [31:0] addr, input int gap, input int abort_at,
                          input int rst_acks);
        logic [31:0] base;
        logic [31:0] pdata;
        int start, k, cyc, busy, pidx;
        bit pend, pend_crit, aborted, done;
        base = addr & ~32'(4 * LW - 1);
        start = int'((addr >> 2) % LW);
        k = 0; cyc = 0; busy = 0; pidx = 0; pdata = 0;
        pend = 0; pend_crit = 0; aborted = 0; done = 0;
        miss_req = 1'b1;
        miss_addr = addr;
        @(negedge CLK);
        if ($urandom_range(0, 1) == 0) miss_req = 1'b0;
        while (!done) begin
            chk("busy", 32'(ifa.Busy), 1);
            busy++;
            chk("fill_vld", 32'(ifa.Fill_Valid), 32'(pend));
            if (pend) begin
                chk("fill_idx", 32'(ifa.Fill_Word_Idx), 32'(pidx));
                chk("fill_dat", ifa.Fill_Data, pdata);
            end
            chk("crit_vld", 32'(ifa.Crit_Valid), 32'(pend_crit));
            if (pend_crit) chk("crit_dat", ifa.Crit_Data, pdata);
            chk("tag_addr", ifa.Fill_Tag_Addr, base);
            if (k == LW) begin
                chk("mem_req_done", 32'(ifa.Mem_Req), 0);
                chk("fill_done", 32'(ifa.Fill_Done), 1);
                miss_req = 1'b0;
                mem_valid = 1'b0;
                abort = 1'b0;
                done = 1;
            end else begin
                chk("mem_req", 32'(ifa.Mem_Req), 1);
                chk("fill_done_early", 32'(ifa.Fill_Done), 0);
                chk("mem_addr", ifa.Mem_Addr, base + 32'(4 * ((start + k) % LW)));
                if (rst_acks >= 0 && k == rst_acks) begin
                    rst_n = 1'b0;
                    mem_valid = 1'b0;
                    abort = 1'b0;
                    miss_req = 1'b0;
                    @(negedge CLK);
                    n_done = 0;
                    check_all_zero("mid_reset");
                    rst_n = 1'b1;
                    return;
                end
                abort = (cyc == abort_at);
                if (abort) aborted = 1;
                mem_valid = ((cyc % (gap + 1)) == gap);
                mem_data = $urandom;
                pend = mem_valid;
                pend_crit = mem_valid && (k == 0) && !aborted;
                pdata = mem_data;
                pidx = (start + k) % LW;
                if (mem_valid) k++;
                cyc++;
                if (cyc > 200) begin
                    chk("refill_timeout", 32'(k), 32'(LW));
                    mem_valid = 1'b0;
                    abort = 1'b0;
                    miss_req = 1'b0;
                    return;
                end
            end
            @(negedge CLK);
        end
        n_done++;
        chk("busy_cycles", 32'(busy), 32'(LW * (gap + 1) + 1));
        chk("idle_busy", 32'(ifa.Busy), 0);
        chk("idle_fill_vld", 32'(ifa.Fill_Valid), 0);
        chk("idle_done", 32'(ifa.Fill_Done), 0);
        check_counts();
        // Stray memory acks in IDLE must not start anything
        for (int i = 0; i < 2; i++) begin
            mem_valid = 1'b1;
            mem_data = $urandom;
            @(negedge CLK);
            chk("stray_mem_req", 32'(ifa.Mem_Req), 0);
            chk("stray_fill_vld", 32'(ifa.Fill_Valid), 0);
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        n_chk = 0; n_err = 0; n_done = 0;
        rst_n = 1'b0;
        miss_req = 1'b0; miss_addr = 32'd0; abort = 1'b0;
        mem_valid = 1'b0; mem_data = 32'd0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge CLK);

        refill(32'h0000_0048, 0, -1, -1);
        refill(32'h0000_0048, 2, -1, -1);
        refill(32'h0000_007C, 0, -1, -1);
        refill(32'h0000_0040, 2, 1, -1);
        refill(32'h0000_0200, 1, -1, 2);
        @(negedge CLK);
        refill(32'h0000_0100, 0, -1, -1);

        for (int t = 0; t < 12; t++) begin
            a = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            refill(a, $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
